// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit frame packer: FSM state codes,
// default SYNC byte and the frame-length helper.
// Optional feature macro: UART_TX_PACK_CHECKSUM_EN (adds a trailing checksum byte).
// No ports (package).
package uart_tx_pkg;

    localparam logic [1:0] S_IDLE        = 2'd0;
    localparam logic [1:0] S_LAUNCH      = 2'd1;
    localparam logic [1:0] S_WAIT_ACTIVE = 2'd2;
    localparam logic [1:0] S_WAIT_DONE   = 2'd3;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

    // Bytes on the line per frame: SYNC + data (+ checksum).
    function automatic int frame_len(input int data_bytes);
`ifdef UART_TX_PACK_CHECKSUM_EN
        return data_bytes + 2;
`else
        return data_bytes + 1;
`endif
    endfunction

endpackage

// File: rtl/uart_tx_frame_packer_if.sv
// Bus bundle between the frame packer, its sample producer and the byte UART.
// Ports (signals): i_Data_Valid, i_Data, o_Data_Ready (producer side);
//   o_Tx_DV, o_Tx_Byte, i_Tx_Active, i_Tx_Done (transmitter side); o_Busy, o_Frame_Done.
// master = packer, slave = environment (producer + transmitter).
interface uart_tx_frame_packer_if #(
    parameter int DATA_BYTES = 4
);

    logic                    i_Data_Valid;
    logic [DATA_BYTES*8-1:0] i_Data;
    logic                    o_Data_Ready;
    logic                    o_Tx_DV;
    logic [7:0]              o_Tx_Byte;
    logic                    i_Tx_Active;
    logic                    i_Tx_Done;
    logic                    o_Busy;
    logic                    o_Frame_Done;

    modport master (
        input  i_Data_Valid, i_Data, i_Tx_Active, i_Tx_Done,
        output o_Data_Ready, o_Tx_DV, o_Tx_Byte, o_Busy, o_Frame_Done
    );

    modport slave (
        output i_Data_Valid, i_Data, i_Tx_Active, i_Tx_Done,
        input  o_Data_Ready, o_Tx_DV, o_Tx_Byte, o_Busy, o_Frame_Done
    );

endinterface

// File: rtl/uart_tx_pack_buf.sv
// Single-entry valid/ready holding register for one pending sample.
// Ports: clk, rst (sync active-high), valid/in_data (producer), take (consumer
//   pops the entry), ready (registered ~full), full, data (held entry).
module uart_tx_pack_buf #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             take,
    output logic             ready,
    output logic             full,
    output logic [WIDTH-1:0] data
);

    logic             full_q;
    logic             rdy_q;
    logic [WIDTH-1:0] data_q;
    logic             accept;
    logic             full_nxt;

    assign accept   = valid & rdy_q;
    // A pop and a fresh accept in the same cycle leave the entry occupied.
    assign full_nxt = accept | (full_q & ~take);

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 1'b0;
            rdy_q  <= 1'b1;
            data_q <= '0;
        end else begin
            full_q <= full_nxt;
            rdy_q  <= ~full_nxt;
            if (accept) begin
                data_q <= in_data;
            end
        end
    end

    assign ready = rdy_q;
    assign full  = full_q;
    assign data  = data_q;

endmodule

// File: rtl/uart_tx_frame_packer.sv
// Serialises one DATA_BYTES-wide sample per frame (SYNC, data MSB-first,
// optional checksum) into byte launches for a byte-wide UART transmitter.
// Ports: i_Clock, i_Reset (sync active-high), bus (uart_tx_frame_packer_if.master).
// Macro UART_TX_PACK_CHECKSUM_EN: append 8-bit sum of data bytes to each frame.
module uart_tx_frame_packer
    import uart_tx_pkg::*;
#(
    parameter int         DATA_BYTES = 4,
    parameter logic [7:0] SYNC_BYTE  = SYNC_DEFAULT
) (
    input logic                    i_Clock,
    input logic                    i_Reset,
    uart_tx_frame_packer_if.master bus
);

    localparam int W  = DATA_BYTES * 8;
    localparam int IW = $clog2(DATA_BYTES + 2);
    localparam logic [IW-1:0] LAST_IDX = IW'(frame_len(DATA_BYTES) - 1);
`ifdef UART_TX_PACK_CHECKSUM_EN
    localparam logic [IW-1:0] CKS_IDX = IW'(DATA_BYTES + 1);
`endif

    logic [1:0]    state_q;
    logic [W-1:0]  shift_q;
    logic [IW-1:0] idx_q;
    logic          tx_dv_q;
    logic [7:0]    tx_byte_q;
    logic          busy_q;
    logic          fdone_q;
`ifdef UART_TX_PACK_CHECKSUM_EN
    logic [7:0]    cks_q;
`endif

    logic          buf_ready;
    logic          buf_full;
    logic [W-1:0]  buf_data;
    logic          take;
    logic [7:0]    next_byte;
    logic [IW-1:0] idx_nxt;

    uart_tx_pack_buf #(
        .WIDTH (W)
    ) u_buf (
        .clk     (i_Clock),
        .rst     (i_Reset),
        .valid   (bus.i_Data_Valid),
        .in_data (bus.i_Data),
        .take    (take),
        .ready   (buf_ready),
        .full    (buf_full),
        .data    (buf_data)
    );

    // Start only with the transmitter fully idle: done may still be high
    // from the previous byte's cleanup, or from a byte that outlived a reset.
    assign take = (state_q == S_IDLE) & buf_full
                & ~bus.i_Tx_Active & ~bus.i_Tx_Done;

    assign next_byte = shift_q[W-1 -: 8];
    assign idx_nxt   = idx_q + 1'b1;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            idx_q     <= '0;
            tx_dv_q   <= 1'b0;
            tx_byte_q <= 8'h00;
            busy_q    <= 1'b0;
            fdone_q   <= 1'b0;
`ifdef UART_TX_PACK_CHECKSUM_EN
            cks_q     <= 8'h00;
`endif
        end else begin
            tx_dv_q <= 1'b0;
            fdone_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (take) begin
                        shift_q   <= buf_data;
                        tx_byte_q <= SYNC_BYTE;
                        idx_q     <= '0;
`ifdef UART_TX_PACK_CHECKSUM_EN
                        cks_q     <= 8'h00;
`endif
                        tx_dv_q   <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    state_q <= S_WAIT_ACTIVE;
                end
                S_WAIT_ACTIVE: begin
                    // Done is ignored here: it can be a leftover of the last byte.
                    if (bus.i_Tx_Active) begin
                        state_q <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (bus.i_Tx_Done) begin
                        if (idx_q != LAST_IDX) begin
                            idx_q   <= idx_nxt;
                            tx_dv_q <= 1'b1;
                            state_q <= S_LAUNCH;
`ifdef UART_TX_PACK_CHECKSUM_EN
                            if (idx_nxt == CKS_IDX) begin
                                tx_byte_q <= cks_q;
                            end else begin
                                tx_byte_q <= next_byte;
                                shift_q   <= shift_q << 8;
                                cks_q     <= cks_q + next_byte;
                            end
`else
                            tx_byte_q <= next_byte;
                            shift_q   <= shift_q << 8;
`endif
                        end else begin
                            fdone_q <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.o_Data_Ready = buf_ready;
    assign bus.o_Tx_DV      = tx_dv_q;
    assign bus.o_Tx_Byte    = tx_byte_q;
    assign bus.o_Busy       = busy_q;
    assign bus.o_Frame_Done = fdone_q;

endmodule
